fan_adc_sampler: RTL and testbench

Front-end sampling stage for the fan controller. It decimates the 4-bit temperature ADC nibble to the controller update rate, averages 2^AVG_LOG2 qualified samples, and delivers the averaged value with a one-cycle `dataVaild_STRB_o` pulse. Its outputs drive the controller's `ADC_value_i` and `dataVaild_STRB_i` inputs directly.

---
 rtl/fan_adc_sampler.sv | 147 ++++++++++++++
 tb/tb_fan_adc_sampler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fan_adc_sampler.sv
// ----------------------------------------------------------------------------
// fan_adc_sampler
//
// Front-end sampling stage for the fan controller. A prescaler turns the
// clk_en_i cadence into sample ticks. On each tick the raw ADC nibble is
// accumulated if ADC_valid_i is high. After 2^AVG_LOG2 accepted samples the
// block spends one PUBLISH cycle, registers the average into ADC_value_o and
// pulses dataVaild_STRB_o for one clk_i cycle.
//
// Build option:
//   FAN_SAMPLER_ROUND_EN  defined   -> round-half-up average
//                         undefined -> floor average (sum >> AVG_LOG2)
//
// Ports:
//   clk_i             rising-edge clock
//   rst_i             synchronous, active-high reset
//   clk_en_i          clock enable for the prescaler
//   config_en_i       high holds the block in HOLD (clears the window)
//   ADC_raw_i         raw unsigned ADC sample
//   ADC_valid_i       raw sample valid, looked at only on a tick
//   ADC_value_o       averaged value, held between strobes
//   dataVaild_STRB_o  one-cycle pulse marking a new ADC_value_o
//   miss_o            sticky: a tick found ADC_valid_i low
// ----------------------------------------------------------------------------
module fan_adc_sampler #(
    parameter int ADC_BITWIDTH = 4,
    parameter int PRESCALE     = 10,
    parameter int AVG_LOG2     = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clk_en_i,
    input  logic                    config_en_i,
    input  logic [ADC_BITWIDTH-1:0] ADC_raw_i,
    input  logic                    ADC_valid_i,
    output logic [ADC_BITWIDTH-1:0] ADC_value_o,
    output logic                    dataVaild_STRB_o,
    output logic                    miss_o
);

    localparam int SUM_W = ADC_BITWIDTH + AVG_LOG2;
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int N_W   = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [N_W-1:0]   N_FULL   = N_W'(1 << AVG_LOG2);

    localparam logic [1:0] ST_ACCUM   = 2'd0;
    localparam logic [1:0] ST_PUBLISH = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    logic [1:0]              state_q,   state_d;
    logic [CNT_W-1:0]        pre_cnt_q, pre_cnt_d;
    logic [SUM_W-1:0]        sum_q,     sum_d;
    logic [N_W-1:0]          n_q,       n_d;
    logic                    miss_q,    miss_d;
    logic [ADC_BITWIDTH-1:0] value_q,   value_d;
    logic                    strobe_q,  strobe_d;

    logic                    tick;
    logic [ADC_BITWIDTH-1:0] avg;

    assign tick = clk_en_i && (pre_cnt_q == PRE_LAST);

    // The average is taken from the top bits of the sum; the sum is sized so
    // that neither the raw sum nor the rounded sum can overflow.
`ifdef FAN_SAMPLER_ROUND_EN
    localparam logic [SUM_W-1:0] ROUND_BIAS = SUM_W'(1 << (AVG_LOG2 - 1));
    logic [SUM_W-1:0] sum_rnd;
    assign sum_rnd = sum_q + ROUND_BIAS;
    assign avg     = sum_rnd[SUM_W-1:AVG_LOG2];
`else
    assign avg     = sum_q[SUM_W-1:AVG_LOG2];
`endif

    always_comb begin
        // NOTE: every _d gets a default first, so no path can infer a latch.
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        sum_d     = sum_q;
        n_d       = n_q;
        miss_d    = miss_q;
        value_d   = value_q;
        strobe_d  = 1'b0;

        if (config_en_i) begin
            // HOLD wins over any tick, including a completing one.
            state_d   = ST_HOLD;
            pre_cnt_d = '0;
            sum_d     = '0;
            n_d       = '0;
            miss_d    = 1'b0;
        end else begin
            if (clk_en_i) begin
                pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + 1'b1;
            end

            // PUBLISH clears the window first; a tick handled below then
            // lands in the fresh window. Leaving HOLD resumes as ACCUM.
            state_d = ST_ACCUM;
            if (state_q == ST_PUBLISH) begin
                value_d  = avg;
                strobe_d = 1'b1;
                sum_d    = '0;
                n_d      = '0;
            end

            if (tick) begin
                if (ADC_valid_i) begin
                    sum_d = sum_d + SUM_W'(ADC_raw_i);
                    n_d   = n_d + 1'b1;
                    if (n_d == N_FULL) begin
                        state_d = ST_PUBLISH;
                    end
                end else begin
                    miss_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state updates use <= so every register samples pre-edge values.
        if (rst_i) begin
            state_q   <= ST_ACCUM;
            pre_cnt_q <= '0;
            sum_q     <= '0;
            n_q       <= '0;
            miss_q    <= 1'b0;
            value_q   <= '0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            sum_q     <= sum_d;
            n_q       <= n_d;
            miss_q    <= miss_d;
            value_q   <= value_d;
            strobe_q  <= strobe_d;
        end
    end

    assign ADC_value_o      = value_q;
    assign dataVaild_STRB_o = strobe_q;
    assign miss_o           = miss_q;

endmodule

// File: tb/tb_fan_adc_sampler.sv
// ----------------------------------------------------------------------------
// tb_fan_adc_sampler
//
// Scoreboard bench for fan_adc_sampler (default parameters). The stimulus
// process pushes the expected value and the expected strobe edge number for
// every window it drives; the monitor pops and compares on each strobe.
// Edge numbering: cyc counts rising edges. A release at count c makes the
// first unreset edge c+1; with clk_en_i high the 4th tick lands on edge
// c+40 and the strobe is raised on edge c+41.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fan_adc_sampler;

    localparam int W = 4;
    localparam int P = 10;
    localparam int L = 2;

    logic         clk_i       = 1'b0;
    logic         rst_i       = 1'b1;
    logic         clk_en_i    = 1'b1;
    logic         config_en_i = 1'b0;
    logic [W-1:0] ADC_raw_i   = '0;
    logic         ADC_valid_i = 1'b1;
    logic [W-1:0] ADC_value_o;
    logic         dataVaild_STRB_o;
    logic         miss_o;

    fan_adc_sampler #(
        .ADC_BITWIDTH(W),
        .PRESCALE    (P),
        .AVG_LOG2    (L)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .clk_en_i        (clk_en_i),
        .config_en_i     (config_en_i),
        .ADC_raw_i       (ADC_raw_i),
        .ADC_valid_i     (ADC_valid_i),
        .ADC_value_o     (ADC_value_o),
        .dataVaild_STRB_o(dataVaild_STRB_o),
        .miss_o          (miss_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] value;
        int unsigned  at;
        string        tag;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_strobe = 1'b0;
    exp_t mon_e;
    always @(negedge clk_i) begin
        if (dataVaild_STRB_o === 1'b1) begin
            check("strobe_width", 32'(prev_strobe), 0);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got strobe at edge %0d value %0d expected none",
                         cyc, ADC_value_o);
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("%s_value", mon_e.tag), 32'(ADC_value_o), 32'(mon_e.value));
                check($sformatf("%s_edge", mon_e.tag), cyc, mon_e.at);
            end
        end
        prev_strobe = dataVaild_STRB_o;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset(output int unsigned c);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        c = cyc;
    endtask

    task automatic sample(logic [W-1:0] v, logic vld);
        ADC_raw_i   = v;
        ADC_valid_i = vld;
        step(P);
    endtask

    task automatic expect_strobe(string tag, logic [W-1:0] v, int unsigned at);
        exp_t e;
        e.value = v;
        e.at    = at;
        e.tag   = tag;
        sb_q.push_back(e);
    endtask

    task automatic check_idle(string tag, logic [W-1:0] v, logic m);
        check($sformatf("%s_value_o", tag), 32'(ADC_value_o), 32'(v));
        check($sformatf("%s_strobe_o", tag), 32'(dataVaild_STRB_o), 0);
        check($sformatf("%s_miss_o", tag), 32'(miss_o), 32'(m));
    endtask

    // Hand-computed window table: four samples, floor and round-half-up.
    logic [W-1:0] vec   [4][4] = '{'{3, 4, 4, 4}, '{15, 15, 15, 15},
                                   '{1, 2, 3, 4}, '{0, 0, 1, 1}};
    logic [W-1:0] e_flr [4]    = '{3, 15, 2, 0};
    logic [W-1:0] e_rnd [4]    = '{4, 15, 3, 1};

`ifdef FAN_SAMPLER_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    // ---------------- stimulus ----------------
    initial begin
        int unsigned c;
        int unsigned c2;

        step(1);

        // 1: reset and steady input 7.
        ADC_raw_i   = 7;
        ADC_valid_i = 1'b1;
        do_reset(c);
        check_idle("s1_reset", 0, 0);
        for (int j = 0; j < 3; j++) expect_strobe("s1", 7, c + 41 + 40 * j);
        step(30);
        check_idle("s1_before", 0, 0);
        step(95);

        // 2: averaging table, windows back to back.
        do_reset(c);
        for (int v = 0; v < 4; v++)
            expect_strobe($sformatf("s2_w%0d", v), ROUND ? e_rnd[v] : e_flr[v], c + 41 + 40 * v);
        for (int v = 0; v < 4; v++)
            for (int k = 0; k < 4; k++) sample(vec[v][k], 1'b1);
        step(5);

        // 3: second tick invalid; average over the four accepted samples.
        // 2+4+6+8 = 20 -> 5 in both builds; the rejected 9 must not count.
        do_reset(c);
        expect_strobe("s3", 5, c + 51);
        sample(2, 1'b1);
        check("s3_miss_before", 32'(miss_o), 0);
        sample(9, 1'b0);
        check("s3_miss_after", 32'(miss_o), 1);
        sample(4, 1'b1);
        sample(6, 1'b1);
        sample(8, 1'b1);

        // 4: three accepted samples, then HOLD for 25 cycles.
        for (int k = 0; k < 3; k++) sample(9, 1'b1);
        check_idle("s4_prehold", 5, 1);
        config_en_i = 1'b1;
        step(25);
        check_idle("s4_hold", 5, 0);
        config_en_i = 1'b0;
        c2 = cyc;
        // 1+1+1+3 = 6 -> floor 1, round 2.
        expect_strobe("s4_post", ROUND ? 4'd2 : 4'd1, c2 + 41);
        sample(1, 1'b1);
        sample(1, 1'b1);
        sample(1, 1'b1);
        sample(3, 1'b1);
        step(5);

        // 4b: config_en_i rises together with the completing tick.
        do_reset(c);
        for (int k = 0; k < 3; k++) sample(2, 1'b1);
        step(9);
        config_en_i = 1'b1;
        step(5);
        check_idle("s4b_drop", 0, 0);
        config_en_i = 1'b0;
        c2 = cyc;
        expect_strobe("s4b_post", 6, c2 + 41);
        for (int k = 0; k < 4; k++) sample(6, 1'b1);
        step(5);

        // 5: clk_en_i toggling every cycle -> strobe period 80.
        ADC_raw_i   = 10;
        ADC_valid_i = 1'b1;
        do_reset(c);
        expect_strobe("s5_a", 10, c + 80);
        expect_strobe("s5_b", 10, c + 160);
        for (int i = 0; i < 170; i++) begin
            step(1);
            clk_en_i = ~clk_en_i;
        end
        clk_en_i = 1'b1;
        step(1);

        // 6: reset in the middle of a window.
        do_reset(c);
        expect_strobe("s6_first", 12, c + 41);
        for (int k = 0; k < 4; k++) sample(12, 1'b1);
        sample(12, 1'b0);
        sample(12, 1'b1);
        sample(12, 1'b1);
        step(5);
        check_idle("s6_prerst", 12, 1);
        do_reset(c);
        check_idle("s6_rst", 0, 0);
        expect_strobe("s6_post", 13, c + 41);
        for (int k = 0; k < 4; k++) sample(13, 1'b1);
        step(5);

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout at edge %0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
